// File: rtl/card_mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : card_mem_arbiter_pkg
// Description : Shared widths, card state encodings and arbiter grant codes
//               for the card memory arbiter and its clients.
// Revision    : 1.0 - initial release
// ============================================================================
package card_mem_arbiter_pkg;

  // Card record field widths
  localparam int CARD_ADDRESS_SIZE = 5;
  localparam int CARD_STATE_SIZE   = 2;
  localparam int CARD_COLOR_SIZE   = 12;

  // Card state encodings stored in the state field
  typedef enum logic [1:0] {
    CARD_EMPTY       = 2'b00,
    CARD_COVERED     = 2'b01,
    CARD_DEACTIVATED = 2'b10,
    CARD_DISCOVERED  = 2'b11
  } card_state_e;

  // Which client owns the memory port in a given cycle
  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_FIFO = 2'd1,
    GNT_INIT = 2'd2,
    GNT_SCAN = 2'd3
  } grant_e;

  // Bits needed to hold a counter that ranges 0..max (never below 1)
  function automatic int ctr_width(input int max_val);
    int w;
    w = $clog2(max_val + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage : card_mem_arbiter_pkg
`default_nettype wire

// File: rtl/card_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : card_mem_arbiter_if
// Description : Bundle of client handshakes and the card RAM port seen by
//               the card memory arbiter. The slave modport is the arbiter
//               view; the master modport is the clients-plus-RAM view.
// Revision    : 1.0 - initial release
// ============================================================================
interface card_mem_arbiter_if #(
  parameter int ADDR_W  = 5,
  parameter int STATE_W = 2,
  parameter int COLOR_W = 12
) ();

  // Game FSM write path
  logic               fsm_wr_en;
  logic [ADDR_W-1:0]  fsm_wr_addr;
  logic [STATE_W-1:0] fsm_wr_state;
  logic               fsm_wr_pending;
  logic               fsm_overflow;

  // Colour initialiser
  logic               init_req;
  logic [ADDR_W-1:0]  init_addr;
  logic [STATE_W-1:0] init_state;
  logic [COLOR_W-1:0] init_color;
  logic               init_gnt;

  // Display scanner
  logic               scan_req;
  logic [ADDR_W-1:0]  scan_addr;
  logic               scan_gnt;
  logic               scan_rvalid;
  logic [STATE_W-1:0] scan_rstate;
  logic [COLOR_W-1:0] scan_rcolor;

  // Card RAM port
  logic               mem_en;
  logic               mem_we_state;
  logic               mem_we_color;
  logic [ADDR_W-1:0]  mem_addr;
  logic [STATE_W-1:0] mem_wstate;
  logic [COLOR_W-1:0] mem_wcolor;
  logic [STATE_W-1:0] mem_rstate;
  logic [COLOR_W-1:0] mem_rcolor;

  modport slave (
    input  fsm_wr_en, fsm_wr_addr, fsm_wr_state,
    output fsm_wr_pending, fsm_overflow,
    input  init_req, init_addr, init_state, init_color,
    output init_gnt,
    input  scan_req, scan_addr,
    output scan_gnt, scan_rvalid, scan_rstate, scan_rcolor,
    output mem_en, mem_we_state, mem_we_color, mem_addr, mem_wstate, mem_wcolor,
    input  mem_rstate, mem_rcolor
  );

  modport master (
    output fsm_wr_en, fsm_wr_addr, fsm_wr_state,
    input  fsm_wr_pending, fsm_overflow,
    output init_req, init_addr, init_state, init_color,
    input  init_gnt,
    output scan_req, scan_addr,
    input  scan_gnt, scan_rvalid, scan_rstate, scan_rcolor,
    input  mem_en, mem_we_state, mem_we_color, mem_addr, mem_wstate, mem_wcolor,
    output mem_rstate, mem_rcolor
  );

endinterface : card_mem_arbiter_if
`default_nettype wire

// File: rtl/card_wr_fifo.sv
`default_nettype none
// ============================================================================
// Module      : card_wr_fifo
// Description : Small synchronous FIFO with full/empty flags. A push while
//               full is accepted only when a pop happens in the same cycle;
//               otherwise it is ignored (the caller flags the overflow).
// Revision    : 1.0 - initial release
// ============================================================================
module card_wr_fifo #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Wrap explicitly so non-power-of-two or single-entry depths still work
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign rdata = store_q[rd_ptr_q];

  // Accept/advance decisions; a full FIFO frees a slot when popped this cycle
  always_comb begin
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? ptr_next(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = do_pop  ? ptr_next(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      store_q[wr_ptr_q] <= wdata;
    end
  end

endmodule : card_wr_fifo
`default_nettype wire

// File: rtl/card_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : card_mem_arbiter
// Description : Shares the single-port card RAM between the game FSM (via a
//               write FIFO), the colour initialiser and the display scanner.
//               Fixed priority FIFO > init > scan, with a starvation guard
//               that hands the port to the scanner after STARVE_MAX
//               consecutive losses. Accesses are registered onto the RAM port
//               the cycle after the grant; read data returns two cycles after
//               the scanner grant.
// Revision    : 1.0 - initial release
// ============================================================================
module card_mem_arbiter
  import card_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = CARD_ADDRESS_SIZE,
  parameter int STATE_W    = CARD_STATE_SIZE,
  parameter int COLOR_W    = CARD_COLOR_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input logic             clk,
  input logic             rst,
  card_mem_arbiter_if.slave bus
);

  localparam int ENTRY_W  = ADDR_W + STATE_W;
  localparam int STARVE_W = ctr_width(STARVE_MAX);

  grant_e             win;
  logic               fifo_full;
  logic               fifo_empty;
  logic               fifo_pop;
  logic [ENTRY_W-1:0] fifo_head;
  logic [ADDR_W-1:0]  head_addr;
  logic [STATE_W-1:0] head_state;

  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                mem_en_q, mem_en_d;
  logic                we_state_q, we_state_d;
  logic                we_color_q, we_color_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [STATE_W-1:0]  wstate_q, wstate_d;
  logic [COLOR_W-1:0]  wcolor_q, wcolor_d;
  logic                rd_issue_q, rd_issue_d;
  logic                rvalid_q, rvalid_d;
  logic [STATE_W-1:0]  rstate_q, rstate_d;
  logic [COLOR_W-1:0]  rcolor_q, rcolor_d;
  logic                overflow_q, overflow_d;
  logic                pending_q, pending_d;

  card_wr_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.fsm_wr_en),
    .pop   (fifo_pop),
    .wdata ({bus.fsm_wr_addr, bus.fsm_wr_state}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign {head_addr, head_state} = fifo_head;
  assign fifo_pop = (win == GNT_FIFO);

  // Pick the single winner for this cycle; nothing is granted while in reset
  always_comb begin
    win = GNT_NONE;
    if (!rst) begin
      if (bus.scan_req && (starve_q == STARVE_W'(STARVE_MAX))) begin
        win = GNT_SCAN;
      end else if (!fifo_empty) begin
        win = GNT_FIFO;
      end else if (bus.init_req) begin
        win = GNT_INIT;
      end else if (bus.scan_req) begin
        win = GNT_SCAN;
      end
    end
  end

  assign bus.init_gnt = (win == GNT_INIT);
  assign bus.scan_gnt = (win == GNT_SCAN);

  // Count consecutive cycles the waiting scanner lost the port
  always_comb begin
    starve_d = starve_q;
    if (!bus.scan_req || (win == GNT_SCAN)) begin
      starve_d = '0;
    end else if ((win == GNT_FIFO) || (win == GNT_INIT)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Build next cycle's RAM port access from the winner
  always_comb begin
    mem_en_d   = 1'b0;
    we_state_d = 1'b0;
    we_color_d = 1'b0;
    addr_d     = '0;
    wstate_d   = '0;
    wcolor_d   = '0;
    case (win)
      GNT_FIFO: begin
        mem_en_d   = 1'b1;
        we_state_d = 1'b1;
        addr_d     = head_addr;
        wstate_d   = head_state;
      end
      GNT_INIT: begin
        mem_en_d   = 1'b1;
        we_state_d = 1'b1;
        we_color_d = 1'b1;
        addr_d     = bus.init_addr;
        wstate_d   = bus.init_state;
        wcolor_d   = bus.init_color;
      end
      GNT_SCAN: begin
        mem_en_d   = 1'b1;
        addr_d     = bus.scan_addr;
      end
      default: ;
    endcase
  end

  // Read-return pipe, held read data, sticky overflow and pending flag
  always_comb begin
    rd_issue_d = (win == GNT_SCAN);
    rvalid_d   = rd_issue_q;
    rstate_d   = rvalid_q ? bus.mem_rstate : rstate_q;
    rcolor_d   = rvalid_q ? bus.mem_rcolor : rcolor_q;
    overflow_d = overflow_q || (bus.fsm_wr_en && fifo_full && !fifo_pop);
    pending_d  = !fifo_empty;
  end

  // All arbiter state; reset discards any in-flight access or read
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_q   <= '0;
      mem_en_q   <= 1'b0;
      we_state_q <= 1'b0;
      we_color_q <= 1'b0;
      addr_q     <= '0;
      wstate_q   <= '0;
      wcolor_q   <= '0;
      rd_issue_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rstate_q   <= '0;
      rcolor_q   <= '0;
      overflow_q <= 1'b0;
      pending_q  <= 1'b0;
    end else begin
      starve_q   <= starve_d;
      mem_en_q   <= mem_en_d;
      we_state_q <= we_state_d;
      we_color_q <= we_color_d;
      addr_q     <= addr_d;
      wstate_q   <= wstate_d;
      wcolor_q   <= wcolor_d;
      rd_issue_q <= rd_issue_d;
      rvalid_q   <= rvalid_d;
      rstate_q   <= rstate_d;
      rcolor_q   <= rcolor_d;
      overflow_q <= overflow_d;
      pending_q  <= pending_d;
    end
  end

  assign bus.mem_en         = mem_en_q;
  assign bus.mem_we_state   = we_state_q;
  assign bus.mem_we_color   = we_color_q;
  assign bus.mem_addr       = addr_q;
  assign bus.mem_wstate     = wstate_q;
  assign bus.mem_wcolor     = wcolor_q;
  assign bus.scan_rvalid    = rvalid_q;
  // Read data is visible in the valid cycle itself, then held
  assign bus.scan_rstate    = rvalid_q ? bus.mem_rstate : rstate_q;
  assign bus.scan_rcolor    = rvalid_q ? bus.mem_rcolor : rcolor_q;
  assign bus.fsm_overflow   = overflow_q;
  assign bus.fsm_wr_pending = pending_q;

endmodule : card_mem_arbiter
`default_nettype wire

// File: tb/tb_card_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_card_mem_arbiter
// Description : Self-checking bench for card_mem_arbiter. A card RAM model
//               serves the port; a transaction-level reference (queue of
//               pending writes, card record array, read snapshots) predicts
//               every output each cycle. Directed sequences pin key timings.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_card_mem_arbiter;
  import card_mem_arbiter_pkg::*;

  localparam int ADDR_W     = 5;
  localparam int STATE_W    = 2;
  localparam int COLOR_W    = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int STARVE_MAX = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  card_mem_arbiter_if #(.ADDR_W(ADDR_W), .STATE_W(STATE_W), .COLOR_W(COLOR_W)) bus ();

  card_mem_arbiter #(
    .ADDR_W(ADDR_W), .STATE_W(STATE_W), .COLOR_W(COLOR_W),
    .FIFO_DEPTH(FIFO_DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- card RAM (1-cycle registered read) ----------------
  logic [STATE_W-1:0] ram_s [32] = '{default: '0};
  logic [COLOR_W-1:0] ram_c [32] = '{default: '0};
  logic [STATE_W-1:0] rd_s = '0;
  logic [COLOR_W-1:0] rd_c = '0;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we_state) ram_s[bus.mem_addr] <= bus.mem_wstate;
      if (bus.mem_we_color) ram_c[bus.mem_addr] <= bus.mem_wcolor;
      if (!bus.mem_we_state && !bus.mem_we_color) begin
        rd_s <= ram_s[bus.mem_addr];
        rd_c <= ram_c[bus.mem_addr];
      end
    end
  end
  assign bus.mem_rstate = rd_s;
  assign bus.mem_rcolor = rd_c;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [ADDR_W-1:0]  a;
    logic [STATE_W-1:0] s;
  } wr_t;

  wr_t                q[$];
  logic [STATE_W+COLOR_W-1:0] snap_q[$];
  logic [STATE_W-1:0] ref_s [32] = '{default: '0};
  logic [COLOR_W-1:0] ref_c [32] = '{default: '0};
  int                 starve = 0;
  int                 g;
  int                 sz;
  wr_t                w;
  bit                 e_en = 0, e_wse = 0, e_wce = 0;
  logic [ADDR_W-1:0]  e_addr = '0;
  logic [STATE_W-1:0] e_wst = '0;
  logic [COLOR_W-1:0] e_wcol = '0;
  bit                 e_pend = 0, e_ovf = 0, rv1 = 0, rv2 = 0;
  logic [STATE_W-1:0] hold_s = '0;
  logic [COLOR_W-1:0] hold_c = '0;

  // Compare every cycle at the falling edge, then advance the model
  always @(negedge clk) begin
    if (rst) begin
      chk("reset_outputs",
          {bus.mem_en, bus.mem_we_state, bus.mem_we_color, bus.mem_addr, bus.mem_wstate,
           bus.init_gnt, bus.scan_gnt, bus.scan_rvalid, bus.fsm_wr_pending,
           bus.fsm_overflow, bus.scan_rstate, bus.scan_rcolor}, 64'd0);
      q.delete();
      snap_q.delete();
      starve = 0;
      e_en = 0; e_wse = 0; e_wce = 0; e_addr = '0; e_wst = '0; e_wcol = '0;
      e_pend = 0; e_ovf = 0; rv1 = 0; rv2 = 0; hold_s = '0; hold_c = '0;
    end else begin
      // the write on the RAM port this cycle is committed at the coming edge
      if (e_en && e_wse) ref_s[e_addr] = e_wst;
      if (e_en && e_wce) ref_c[e_addr] = e_wcol;
      sz = q.size();
      if (bus.scan_req && starve == STARVE_MAX) g = 3;
      else if (sz > 0)                          g = 1;
      else if (bus.init_req)                    g = 2;
      else if (bus.scan_req)                    g = 3;
      else                                      g = 0;

      chk("init_gnt", bus.init_gnt, g == 2);
      chk("scan_gnt", bus.scan_gnt, g == 3);
      chk("mem_en", bus.mem_en, e_en);
      if (e_en) begin
        chk("mem_access", {bus.mem_we_state, bus.mem_we_color, bus.mem_addr, bus.mem_wstate},
            {e_wse, e_wce, e_addr, e_wst});
        if (e_wce) chk("mem_wcolor", bus.mem_wcolor, e_wcol);
      end
      chk("scan_rvalid", bus.scan_rvalid, rv2);
      if (rv2) begin
        if (snap_q.size() == 0) chk("read_without_grant", 1, 0);
        else {hold_s, hold_c} = snap_q.pop_front();
      end
      chk("scan_rdata", {bus.scan_rstate, bus.scan_rcolor}, {hold_s, hold_c});
      chk("fsm_wr_pending", bus.fsm_wr_pending, e_pend);
      chk("fsm_overflow", bus.fsm_overflow, e_ovf);

      e_pend = (sz > 0);
      e_en = 0; e_wse = 0; e_wce = 0; e_addr = '0; e_wst = '0; e_wcol = '0;
      if (g == 1) begin
        w = q.pop_front();
        e_en = 1; e_wse = 1; e_addr = w.a; e_wst = w.s;
      end else if (g == 2) begin
        e_en = 1; e_wse = 1; e_wce = 1;
        e_addr = bus.init_addr; e_wst = bus.init_state; e_wcol = bus.init_color;
      end else if (g == 3) begin
        e_en = 1; e_addr = bus.scan_addr;
        snap_q.push_back({ref_s[bus.scan_addr], ref_c[bus.scan_addr]});
      end
      if (bus.fsm_wr_en) begin
        if (sz == FIFO_DEPTH && g != 1) e_ovf = 1;
        else begin
          w.a = bus.fsm_wr_addr; w.s = bus.fsm_wr_state;
          q.push_back(w);
        end
      end
      starve = (!bus.scan_req || g == 3) ? 0 : starve + 1;
      rv2 = rv1;
      rv1 = (g == 3);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.fsm_wr_en = 0; bus.fsm_wr_addr = '0; bus.fsm_wr_state = '0;
    bus.init_req = 0; bus.init_addr = '0; bus.init_state = '0; bus.init_color = '0;
    bus.scan_req = 0; bus.scan_addr = '0;
  endtask

  initial begin
    int k;
    idle_inputs();
    rst = 1;
    repeat (3) step();
    rst = 0;
    #1;
    chk("after_reset", {bus.mem_en, bus.fsm_wr_pending, bus.fsm_overflow, bus.scan_rvalid}, 0);

    // single FSM write
    step(); bus.fsm_wr_en = 1; bus.fsm_wr_addr = 5'd5; bus.fsm_wr_state = CARD_DISCOVERED;
    step(); bus.fsm_wr_en = 0;
    #1 chk("single_no_bypass", {bus.mem_en, bus.fsm_wr_pending}, 2'b00);
    step(); #1;
    chk("single_issue", {bus.mem_en, bus.mem_we_state, bus.mem_we_color, bus.mem_addr, bus.mem_wstate},
        {1'b1, 1'b1, 1'b0, 5'd5, 2'b11});
    chk("single_pending_hi", bus.fsm_wr_pending, 1);
    step(); #1;
    chk("single_pending_lo", {bus.fsm_wr_pending, bus.mem_en}, 2'b00);

    // FSM pair ahead of a concurrent initialiser request
    step(); bus.fsm_wr_en = 1; bus.fsm_wr_addr = 5'd3; bus.fsm_wr_state = CARD_COVERED;
    step(); bus.fsm_wr_addr = 5'd9;
    bus.init_req = 1; bus.init_addr = 5'd20; bus.init_state = 2'b11; bus.init_color = 12'hABC;
    #1 chk("pair_init_wait1", bus.init_gnt, 0);
    step(); bus.fsm_wr_en = 0;
    #1 chk("pair_init_wait2", bus.init_gnt, 0);
    chk("pair_first", {bus.mem_we_state, bus.mem_addr}, {1'b1, 5'd3});
    step(); #1;
    chk("pair_init_gnt", bus.init_gnt, 1);
    chk("pair_second", {bus.mem_we_state, bus.mem_addr}, {1'b1, 5'd9});
    step(); bus.init_req = 0;
    #1 chk("pair_init_issue", {bus.mem_we_state, bus.mem_we_color, bus.mem_addr, bus.mem_wcolor},
           {1'b1, 1'b1, 5'd20, 12'hABC});
    repeat (2) step();

    // starvation guard: init, init, init, scan, ...
    bus.init_req = 1; bus.init_addr = 5'd11; bus.init_color = 12'h123;
    bus.scan_req = 1; bus.scan_addr = 5'd20;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("starve_seq", {bus.init_gnt, bus.scan_gnt}, (i % 4 == 3) ? 2'b01 : 2'b10);
      chk("starve_rvalid", bus.scan_rvalid, (i == 5));
      step();
    end
    bus.init_req = 0; bus.scan_req = 0;
    repeat (4) step();

    // six pushes against a held init request never fill the FIFO
    bus.init_req = 1;
    for (int i = 0; i < 6; i++) begin
      bus.fsm_wr_en = 1; bus.fsm_wr_addr = 5'(i + 12); bus.fsm_wr_state = 2'(i);
      step();
    end
    bus.fsm_wr_en = 0;
    repeat (4) step();
    bus.init_req = 0;
    #1 chk("no_overflow", bus.fsm_overflow, 0);
    repeat (2) step();

    // read after write to the same card
    bus.fsm_wr_en = 1; bus.fsm_wr_addr = 5'd7; bus.fsm_wr_state = CARD_DEACTIVATED;
    step(); bus.fsm_wr_en = 0; bus.scan_req = 1; bus.scan_addr = 5'd7;
    #1; k = 0;
    while (!bus.scan_gnt && k < 10) begin step(); #1; k++; end
    chk("raw_gnt_seen", bus.scan_gnt, 1);
    step(); bus.scan_req = 0;
    step(); #1;
    chk("raw_rvalid", bus.scan_rvalid, 1);
    chk("raw_rstate", bus.scan_rstate, 2'b10);
    repeat (2) step();

    // scanner past its limit steals cycles until the FIFO overflows
    bus.scan_req = 1; bus.scan_addr = 5'd1;
    for (int i = 0; i < 24; i++) begin
      bus.fsm_wr_en = 1; bus.fsm_wr_addr = 5'($urandom); bus.fsm_wr_state = 2'($urandom);
      step();
    end
    bus.fsm_wr_en = 0; bus.scan_req = 0;
    #1 chk("overflow_set", bus.fsm_overflow, 1);
    repeat (8) step();

    // reset with a scan in flight and FIFO occupied
    bus.scan_req = 1; bus.scan_addr = 5'd4; bus.fsm_wr_en = 1; bus.fsm_wr_addr = 5'd1;
    step(); bus.scan_req = 0; bus.fsm_wr_addr = 5'd2;
    #1 rst = 1;
    #1 chk("async_reset",
           {bus.mem_en, bus.init_gnt, bus.scan_gnt, bus.scan_rvalid,
            bus.fsm_wr_pending, bus.fsm_overflow, bus.scan_rstate}, 0);
    bus.fsm_wr_en = 0;
    repeat (2) step();
    rst = 0;
    for (int i = 0; i < 5; i++) begin
      #1 chk("post_reset_quiet", {bus.mem_en, bus.scan_rvalid, bus.fsm_wr_pending}, 0);
      step();
    end

    // randomized traffic, including occasional mid-run resets
    for (int i = 0; i < 1500; i++) begin
      bus.fsm_wr_en    = ($urandom_range(0, 3) == 0);
      bus.fsm_wr_addr  = 5'($urandom);
      bus.fsm_wr_state = 2'($urandom);
      bus.init_req     = ($urandom_range(0, 2) == 0);
      bus.init_addr    = 5'($urandom);
      bus.init_state   = 2'($urandom);
      bus.init_color   = 12'($urandom);
      bus.scan_req     = ($urandom_range(0, 1) == 0);
      bus.scan_addr    = 5'($urandom);
      if ($urandom_range(0, 399) == 0) begin
        rst = 1;
        repeat (2) step();
        rst = 0;
      end
      step();
    end
    idle_inputs();
    repeat (5) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_card_mem_arbiter
`default_nettype wire
